tag_array_ctrl: RTL
===================

Name: tag_array_ctrl

Overview:
- Client-side controller that drives a 64-set x 8-way tag SRAM (184-bit rows = 8 x 23-bit way entries, 1R1W, per-way write mask, 1-cycle registered read).
- Accepts lookup / fill / invalidate requests over a valid/ready channel, performs way compare, and returns hit/way over a valid/ready response channel.
- After reset it sweeps all sets to zero before accepting requests.
- Sits between the cache pipeline and the tag SRAM macro.

Parameters:
- SETS, 64, number of sets; the set index is log2(SETS)=6 bits.
- WAYS, 8, number of ways; the way index is 3 bits.
- TAG_W, 22, tag bits per way.
- ENTRY_W, 23, bits per way entry: valid at bit 22, tag at bits 21:0.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_op  in  2  0=LOOKUP, 1=FILL, 2=INVAL, 3=reserved (accepted, treated as no-op, no response).
- req_set  in  6  set index.
- req_tag  in  22  tag for LOOKUP/FILL.
- req_way  in  3  target way for FILL/INVAL.
- resp_valid  out  1  lookup result valid.
- resp_ready  in  1  consumer accepts the response.
- resp_hit  out  1  some valid way matched.
- resp_way  out  3  lowest-index matching way (0 if miss).
- resp_multi  out  1  more than one way matched (error flag).
- init_done  out  1  set when the reset sweep completes.
- tag_R0_addr  out  6  SRAM read address.
- tag_R0_en  out  1  SRAM read enable.
- tag_R0_data  in  184  SRAM read data, valid the cycle after tag_R0_en.
- tag_W0_addr  out  6  SRAM write address.
- tag_W0_en  out  1  SRAM write enable.
- tag_W0_data  out  184  SRAM write data, the entry replicated in all 8 way slots.
- tag_W0_mask  out  8  one-hot way mask (all ones during the sweep).

Behaviour:
- Reset values: all outputs 0; state=INIT; sweep counter=0.
- All SRAM port outputs are registered.
- States: INIT -> IDLE; IDLE -> RD | WR; RD -> CMP -> RESP -> IDLE; WR -> IDLE.
- INIT:
  - Each cycle: W0_en=1, W0_addr=counter, W0_data=0, W0_mask=8'hFF.
  - Counter increments; after the write to set 63, go to IDLE and set init_done=1 (held until reset).
  - Sweep takes exactly 64 write cycles; req_ready=0 throughout.
- IDLE: req_ready=1 only in IDLE. Request accepted in cycle N:
  - LOOKUP: R0_en=1, R0_addr=set in N+1 (state RD). Data is sampled in N+2 (CMP). The compare result is registered, and resp_valid=1 from N+3 (RESP).
  - FILL: in N+1, W0_en=1, W0_addr=set, W0_mask=1<<way, W0_data=replicated {1'b1, tag} (state WR). req_ready returns in N+2.
  - INVAL: same as FILL with entry = 0.
  - reserved op: stay in IDLE; no SRAM activity.
- Compare: way i hits iff data[23*i+22]==1 and data[23*i+:22]==captured tag.
  - resp_hit = OR of all way hits.
  - resp_way = priority encode, lowest index wins.
  - resp_multi = popcount > 1.
- RESP:
  - resp_valid, resp_hit, resp_way and resp_multi are held stable until resp_ready.
  - When resp_ready is seen, go to IDLE the next cycle.
  - resp_ready in the same cycle resp_valid first rises is legal (single-cycle response).
- Exactly one operation is outstanding at a time.
- Back-to-back: fill at N, lookup at N+2 to the same set must observe the fill. The SRAM write has settled before R0 is asserted at N+3.
- Request fields are captured at acceptance; later changes on req_* are ignored.
- Reset asserted in any state, including mid-sweep or mid-response:
  - Next cycle all outputs are 0, state=INIT, and the sweep restarts at set 0.
  - A pending response is dropped.
- tag_R0_en and tag_W0_en are never both high in the same cycle.

Decomposition:
- Package tag_array_pkg:
  - op enum (LOOKUP/FILL/INVAL/RSVD) and state enum.
  - Constants SETS, WAYS, TAG_W, ENTRY_W.
  - Entry struct {valid, tag}.
- Sub-module tag_way_match: combinational 8-way compare that outputs the hit vector, lowest-index encode and multi flag. Unit-testable on its own.

Test Plan:
- Reset then idle -> W0_en high for exactly 64 cycles, addrs 0..63, mask FF, data 0; init_done rises on the cycle after the last write; req_ready=1 thereafter.
- After init, LOOKUP set 5 tag 0x12345 -> R0_en at N+1 with addr 5; resp_valid at N+3 with hit=0, way=0, multi=0.
- FILL set 5 way 3 tag 0x12345, then LOOKUP set 5 tag 0x12345 -> W0_mask=8'h08; W0_data bits [91:69]=0x412345; lookup gives hit=1, way=3, multi=0.
- FILL the same tag into ways 6 and 2 of set 9, then LOOKUP -> hit=1, way=2, multi=1. Then INVAL way 2, LOOKUP -> hit=1, way=6, multi=0.
- Lookup response with resp_ready held low for 5 cycles -> response fields stable, req_ready=0 throughout; release -> IDLE the next cycle.
- Assert reset at sweep count 30 and again while in RESP -> outputs clear, sweep restarts at addr 0, full 64-cycle sweep completes, no stale resp_valid.

Source files
------------

// File: rtl/tag_array_pkg.sv
// Shared types and constants for the tag SRAM controller: request opcodes,
// controller states and the per-way entry layout.
package tag_array_pkg;

   localparam int SETS    = 64;
   localparam int WAYS    = 8;
   localparam int TAG_W   = 22;
   localparam int ENTRY_W = 23;
   localparam int SET_W   = $clog2(SETS);
   localparam int WAY_W   = $clog2(WAYS);
   localparam int ROW_W   = WAYS * ENTRY_W;

   typedef enum logic [1:0] {
      OP_LOOKUP = 2'd0,
      OP_FILL   = 2'd1,
      OP_INVAL  = 2'd2,
      OP_RSVD   = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_RD,
      ST_CMP,
      ST_RESP,
      ST_WR
   } state_e;

   // Valid sits above the tag so the packed struct matches the SRAM slot layout.
   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
   } entry_t;

   function automatic logic [ROW_W-1:0] replicate_entry(entry_t e);
      return {WAYS{e}};
   endfunction

endpackage

// File: rtl/tag_array_ctrl_if.sv
// Request/response channel between the cache pipeline (master) and the
// tag array controller (slave).
interface tag_array_ctrl_if;
   import tag_array_pkg::*;

   logic             req_valid;
   logic             req_ready;
   op_e              req_op;
   logic [SET_W-1:0] req_set;
   logic [TAG_W-1:0] req_tag;
   logic [WAY_W-1:0] req_way;
   logic             resp_valid;
   logic             resp_ready;
   logic             resp_hit;
   logic [WAY_W-1:0] resp_way;
   logic             resp_multi;

   modport master (
      output req_valid, req_op, req_set, req_tag, req_way, resp_ready,
      input  req_ready, resp_valid, resp_hit, resp_way, resp_multi
   );

   modport slave (
      input  req_valid, req_op, req_set, req_tag, req_way, resp_ready,
      output req_ready, resp_valid, resp_hit, resp_way, resp_multi
   );

endinterface

// File: rtl/tag_way_match.sv
// Combinational 8-way tag compare: per-way hit vector, lowest matching way
// and a flag for more than one matching way.
module tag_way_match
   import tag_array_pkg::*;
(
   input  logic [ROW_W-1:0] row,
   input  logic [TAG_W-1:0] tag,
   output logic [WAYS-1:0]  hit_vec,
   output logic [WAY_W-1:0] way,
   output logic             multi
);

   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         entry_t slot;
         assign slot        = row[gi*ENTRY_W +: ENTRY_W];
         assign hit_vec[gi] = slot.valid && (slot.tag == tag);
      end
   endgenerate

   // Scan from the top so the lowest-index hit is the last one written.
   always_comb begin
      way = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (hit_vec[i]) way = WAY_W'(i);
      end
   end

   // Clearing the lowest set bit leaves something only when two or more ways hit.
   assign multi = |(hit_vec & (hit_vec - WAYS'(1)));

endmodule

// File: rtl/tag_array_ctrl.sv
// Tag SRAM client controller: zero-sweeps all sets after reset, then serves
// lookup/fill/invalidate requests one at a time with registered SRAM ports.
module tag_array_ctrl
   import tag_array_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   tag_array_ctrl_if.slave  bus,
   output logic             init_done,
   output logic [SET_W-1:0] tag_R0_addr,
   output logic             tag_R0_en,
   input  logic [ROW_W-1:0] tag_R0_data,
   output logic [SET_W-1:0] tag_W0_addr,
   output logic             tag_W0_en,
   output logic [ROW_W-1:0] tag_W0_data,
   output logic [WAYS-1:0]  tag_W0_mask
);

   state_e             state_reg,      state_next;
   logic [SET_W:0]     cnt_reg,        cnt_next;
   logic               init_done_reg,  init_done_next;
   logic               r0_en_reg,      r0_en_next;
   logic [SET_W-1:0]   r0_addr_reg,    r0_addr_next;
   logic               w0_en_reg,      w0_en_next;
   logic [SET_W-1:0]   w0_addr_reg,    w0_addr_next;
   logic [ROW_W-1:0]   w0_data_reg,    w0_data_next;
   logic [WAYS-1:0]    w0_mask_reg,    w0_mask_next;
   logic [TAG_W-1:0]   tag_reg,        tag_next;
   logic               resp_valid_reg, resp_valid_next;
   logic               resp_hit_reg,   resp_hit_next;
   logic [WAY_W-1:0]   resp_way_reg,   resp_way_next;
   logic               resp_multi_reg, resp_multi_next;

   logic [WAYS-1:0]    match_vec;
   logic [WAY_W-1:0]   match_way;
   logic               match_multi;
   entry_t             fill_entry;

   tag_way_match u_match (
      .row     (tag_R0_data),
      .tag     (tag_reg),
      .hit_vec (match_vec),
      .way     (match_way),
      .multi   (match_multi)
   );

   // INVAL writes an all-zero entry into the selected way.
   assign fill_entry = '{valid: (bus.req_op == OP_FILL),
                         tag:   (bus.req_op == OP_FILL) ? bus.req_tag : '0};

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      init_done_next  = init_done_reg;
      r0_en_next      = 1'b0;
      r0_addr_next    = r0_addr_reg;
      w0_en_next      = 1'b0;
      w0_addr_next    = w0_addr_reg;
      w0_data_next    = '0;
      w0_mask_next    = '0;
      tag_next        = tag_reg;
      resp_valid_next = resp_valid_reg;
      resp_hit_next   = resp_hit_reg;
      resp_way_next   = resp_way_reg;
      resp_multi_next = resp_multi_reg;

      case (state_reg)
         // The extra count past the last set lets init_done rise one cycle
         // after the final sweep write is presented on W0.
         ST_INIT: begin
            if (cnt_reg == (SET_W+1)'(SETS)) begin
               state_next     = ST_IDLE;
               init_done_next = 1'b1;
            end else begin
               w0_en_next   = 1'b1;
               w0_addr_next = cnt_reg[SET_W-1:0];
               w0_mask_next = '1;
               cnt_next     = cnt_reg + 1'b1;
            end
         end
         ST_IDLE: begin
            if (bus.req_valid) begin
               case (bus.req_op)
                  OP_LOOKUP: begin
                     r0_en_next   = 1'b1;
                     r0_addr_next = bus.req_set;
                     tag_next     = bus.req_tag;
                     state_next   = ST_RD;
                  end
                  OP_FILL, OP_INVAL: begin
                     w0_en_next   = 1'b1;
                     w0_addr_next = bus.req_set;
                     w0_mask_next = WAYS'(1) << bus.req_way;
                     w0_data_next = replicate_entry(fill_entry);
                     state_next   = ST_WR;
                  end
                  default: ;
               endcase
            end
         end
         ST_RD: state_next = ST_CMP;
         ST_CMP: begin
            resp_valid_next = 1'b1;
            resp_hit_next   = |match_vec;
            resp_way_next   = match_way;
            resp_multi_next = match_multi;
            state_next      = ST_RESP;
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               resp_valid_next = 1'b0;
               state_next      = ST_IDLE;
            end
         end
         ST_WR:   state_next = ST_IDLE;
         default: state_next = ST_INIT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= ST_INIT;
         cnt_reg        <= '0;
         init_done_reg  <= 1'b0;
         r0_en_reg      <= 1'b0;
         r0_addr_reg    <= '0;
         w0_en_reg      <= 1'b0;
         w0_addr_reg    <= '0;
         w0_data_reg    <= '0;
         w0_mask_reg    <= '0;
         tag_reg        <= '0;
         resp_valid_reg <= 1'b0;
         resp_hit_reg   <= 1'b0;
         resp_way_reg   <= '0;
         resp_multi_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         init_done_reg  <= init_done_next;
         r0_en_reg      <= r0_en_next;
         r0_addr_reg    <= r0_addr_next;
         w0_en_reg      <= w0_en_next;
         w0_addr_reg    <= w0_addr_next;
         w0_data_reg    <= w0_data_next;
         w0_mask_reg    <= w0_mask_next;
         tag_reg        <= tag_next;
         resp_valid_reg <= resp_valid_next;
         resp_hit_reg   <= resp_hit_next;
         resp_way_reg   <= resp_way_next;
         resp_multi_reg <= resp_multi_next;
      end
   end

   assign bus.req_ready  = (state_reg == ST_IDLE);
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_hit   = resp_hit_reg;
   assign bus.resp_way   = resp_way_reg;
   assign bus.resp_multi = resp_multi_reg;
   assign init_done      = init_done_reg;
   assign tag_R0_en      = r0_en_reg;
   assign tag_R0_addr    = r0_addr_reg;
   assign tag_W0_en      = w0_en_reg;
   assign tag_W0_addr    = w0_addr_reg;
   assign tag_W0_data    = w0_data_reg;
   assign tag_W0_mask    = w0_mask_reg;

endmodule
